instr_fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_buffer.sv | 68 ++++++
 rtl/instr_fetch_unit.sv | 127 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   fetch_state_t : fetch FSM states
//   NOP_INSTR     : substitute word delivered with an address-misaligned fault
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,   // ready to issue a request for PC_Curr
    StWait,   // one request granted, awaiting its response
    StDrop,   // request was flushed, its response must be swallowed
    StFault   // misaligned PC reported, parked until a redirect
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry valid/ready holding register between fetch and decode.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   load_i            : capture instr/pc/fault payload and raise valid
//   flush_i           : drop the entry (clears valid and fault); wins over load
//   ready_i           : consumer accepts the entry this cycle
//   instr_i/pc_i/fault_i : payload to capture
//   valid_o, instr_o, pc_o, fault_o : registered entry
module fetch_buffer #(
  parameter int unsigned AddrSize = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic                flush_i,
  input  logic                ready_i,
  input  logic [31:0]         instr_i,
  input  logic [AddrSize-1:0] pc_i,
  input  logic                fault_i,
  output logic                valid_o,
  output logic [31:0]         instr_o,
  output logic [AddrSize-1:0] pc_o,
  output logic                fault_o
);

  logic                valid_q, valid_d;
  logic                fault_q, fault_d;
  logic [31:0]         instr_q, instr_d;
  logic [AddrSize-1:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    fault_d = fault_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
      fault_d = 1'b0;
    end else if (load_i) begin
      // A load in the consume cycle simply replaces the entry.
      valid_d = 1'b1;
      fault_d = fault_i;
      instr_d = instr_i;
      pc_d    = pc_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      fault_q <= fault_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign fault_o = fault_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one instruction-memory request at a time for
// PC_Curr, hands the returned word to decode through a one-entry buffer, and
// reports misaligned PCs as a faulting NOP until redirected by flush.
//   clk, reset            : clock, asynchronous active-high reset
//   PC_Curr               : address to fetch; pc_advance tells upstream to step it
//   flush                 : redirect, discards all fetch work in progress
//   imem_req/addr/gnt     : request handshake to instruction memory
//   imem_rvalid/rdata     : response from instruction memory
//   out_valid/ready       : handshake to decode
//   out_instr/pc/fault    : instruction word, its address, misalignment flag
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned AddrSize = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [AddrSize-1:0] PC_Curr,
  output logic                pc_advance,
  input  logic                flush,
  output logic                imem_req,
  output logic [AddrSize-1:0] imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic [AddrSize-1:0] out_pc,
  output logic                out_fault
);

  fetch_state_t        state_q, state_d;
  logic [AddrSize-1:0] req_pc_q, req_pc_d;

  logic                buf_free;
  logic                pc_aligned;
  logic                ld;
  logic [31:0]         ld_instr;
  logic [AddrSize-1:0] ld_pc;
  logic                ld_fault;

  assign buf_free   = !out_valid || out_ready;
  assign pc_aligned = (PC_Curr[1:0] == 2'b00);
  assign imem_addr  = PC_Curr;

  always_comb begin
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    imem_req   = 1'b0;
    pc_advance = 1'b0;
    ld         = 1'b0;
    ld_instr   = imem_rdata;
    ld_pc      = req_pc_q;
    ld_fault   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!flush && buf_free) begin
          if (pc_aligned) begin
            imem_req = 1'b1;
            if (imem_gnt) begin
              state_d  = StWait;
              req_pc_d = PC_Curr;
            end
          end else begin
            ld       = 1'b1;
            ld_instr = NOP_INSTR;
            ld_pc    = PC_Curr;
            ld_fault = 1'b1;
            state_d  = StFault;
          end
        end
      end
      StWait: begin
        if (flush) begin
          // A response landing with the flush closes the transaction at once.
          state_d = imem_rvalid ? StIdle : StDrop;
        end else if (imem_rvalid) begin
          ld         = 1'b1;
          pc_advance = 1'b1;
          state_d    = StIdle;
        end
      end
      StDrop: begin
        // Only the outstanding response ends DROP; a flush alone changes nothing.
        if (imem_rvalid) state_d = StIdle;
      end
      StFault: begin
        if (flush) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // IDLE is the reset state, so the request must be masked while reset is held.
    if (reset) begin
      imem_req   = 1'b0;
      pc_advance = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_buffer #(
    .AddrSize(AddrSize)
  ) u_fetch_buffer (
    .clk_i   (clk),
    .rst_i   (reset),
    .load_i  (ld),
    .flush_i (flush),
    .ready_i (out_ready),
    .instr_i (ld_instr),
    .pc_i    (ld_pc),
    .fault_i (ld_fault),
    .valid_o (out_valid),
    .instr_o (out_instr),
    .pc_o    (out_pc),
    .fault_o (out_fault)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations,
// then randomized traffic against a transaction-level model and memory model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_curr;
  logic        flush, gnt, rvalid, ready;
  logic [31:0] rdata;
  logic        pc_advance, imem_req, out_valid, out_fault;
  logic [31:0] imem_addr, out_instr, out_pc;

  instr_fetch_unit #(
    .AddrSize(32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .PC_Curr     (pc_curr),
    .pc_advance  (pc_advance),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (gnt),
    .imem_rvalid (rvalid),
    .imem_rdata  (rdata),
    .out_valid   (out_valid),
    .out_ready   (ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_fault   (out_fault)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int adv_cnt;

  // Model: a granted fetch in flight, a flushed one whose reply must be eaten,
  // a fault parked until redirect, and the decode-side entry.
  bit          m_busy, m_drop, m_fault;
  logic [31:0] m_req_pc;
  bit          b_v, b_f;
  logic [31:0] b_i, b_pc;
  bit          e_req, e_adv;

  // Outputs sampled in the most recent step.
  logic        s_req, s_adv, s_ov, s_of;
  logic [31:0] s_addr, s_oi, s_opc;

  // Memory model for the random phase.
  bit          mem_pend;
  int          mem_cnt;
  logic [31:0] mem_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    m_busy = 0; m_drop = 0; m_fault = 0; m_req_pc = '0;
    b_v = 0; b_f = 0; b_i = '0; b_pc = '0;
    mem_pend = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst imem_req", imem_req, 0);
    chk("rst pc_advance", pc_advance, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_fault", out_fault, 0);
    chk("rst out_instr", out_instr, 0);
    chk("rst out_pc", out_pc, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic step(input logic [31:0] pc, input bit fl, input bit g, input bit rv,
                      input logic [31:0] rd, input bit rdy);
    bit free, idle;
    @(negedge clk);
    pc_curr = pc; flush = fl; gnt = g; rvalid = rv; rdata = rd; ready = rdy;
    #1;
    free  = !b_v || rdy;
    idle  = !m_busy && !m_drop && !m_fault;
    e_req = idle && !fl && (pc[1:0] == 2'b00) && free;
    e_adv = m_busy && rv && !fl;
    s_req = imem_req; s_addr = imem_addr; s_adv = pc_advance;
    s_ov = out_valid; s_oi = out_instr; s_opc = out_pc; s_of = out_fault;
    chk("imem_req", s_req, e_req);
    if (e_req) chk("imem_addr", s_addr, pc);
    chk("pc_advance", s_adv, e_adv);
    chk("out_valid", s_ov, b_v);
    if (b_v) begin
      chk("out_instr", s_oi, b_i);
      chk("out_pc", s_opc, b_pc);
      chk("out_fault", s_of, b_f);
    end
    if (e_adv) adv_cnt++;
    if (fl) begin
      b_v = 0; b_f = 0; m_fault = 0;
      if (m_busy) begin
        m_busy = 0;
        m_drop = !rv;
      end else if (m_drop && rv) begin
        m_drop = 0;
      end
    end else begin
      if (b_v && rdy) b_v = 0;
      if (m_busy && rv) begin
        b_v = 1; b_i = rd; b_pc = m_req_pc; b_f = 0; m_busy = 0;
      end else if (m_drop && rv) begin
        m_drop = 0;
      end else if (idle && free && pc[1:0] != 2'b00) begin
        b_v = 1; b_i = 32'h00000013; b_pc = pc; b_f = 1; m_fault = 1;
      end else if (e_req && g) begin
        m_busy = 1; m_req_pc = pc;
      end
    end
  endtask

  initial begin
    logic [31:0] pc;
    bit fl, g, rv, rdy;
    logic [31:0] rd;
    reset = 0; pc_curr = 32'h100; flush = 0; gnt = 0; rvalid = 0; rdata = '0; ready = 1;
    model_clear();
    do_reset();

    // Basic fetch: grant at once, data two cycles later.
    adv_cnt = 0;
    step(32'h100, 0, 1, 0, 32'h0, 1);
    chk("A req", s_req, 1); chk("A addr", s_addr, 32'h100);
    step(32'h100, 0, 0, 0, 32'h0, 1);
    step(32'h100, 0, 0, 1, 32'h00500093, 1);
    chk("A adv", s_adv, 1);
    step(32'h104, 0, 0, 0, 32'h0, 1);
    chk("A valid", s_ov, 1); chk("A pc", s_opc, 32'h100); chk("A instr", s_oi, 32'h00500093);
    chk("A adv count", adv_cnt, 1);

    // Grant withheld for three cycles.
    adv_cnt = 0;
    repeat (3) begin
      step(32'h104, 0, 0, 0, 32'h0, 1);
      chk("B req", s_req, 1); chk("B addr", s_addr, 32'h104); chk("B adv", s_adv, 0);
    end
    step(32'h104, 0, 1, 0, 32'h0, 1);
    step(32'h104, 0, 0, 1, 32'h00A00113, 1);
    chk("B adv", s_adv, 1); chk("B adv count", adv_cnt, 1);

    // Decode stalls for four cycles.
    repeat (4) begin
      step(32'h108, 0, 1, 0, 32'h0, 0);
      chk("C req", s_req, 0); chk("C valid", s_ov, 1); chk("C instr", s_oi, 32'h00A00113);
    end
    step(32'h108, 0, 0, 0, 32'h0, 1);
    chk("C resume req", s_req, 1); chk("C resume addr", s_addr, 32'h108);

    // Flush one cycle after grant; stale reply arrives two cycles later.
    step(32'h108, 0, 1, 0, 32'h0, 1);
    chk("D req", s_req, 1);
    adv_cnt = 0;
    step(32'h108, 1, 0, 0, 32'h0, 1);
    step(32'h200, 0, 0, 0, 32'h0, 1);
    chk("D drop req", s_req, 0);
    step(32'h200, 0, 0, 1, 32'h12345678, 1);
    chk("D stale adv", s_adv, 0);
    step(32'h200, 0, 0, 0, 32'h0, 1);
    chk("D valid", s_ov, 0); chk("D new req", s_req, 1); chk("D new addr", s_addr, 32'h200);
    chk("D adv count", adv_cnt, 0);

    // Misaligned PC.
    step(32'h200, 1, 0, 0, 32'h0, 1);
    step(32'h102, 0, 1, 0, 32'h0, 0);
    chk("E req", s_req, 0);
    repeat (3) begin
      step(32'h102, 0, 1, 0, 32'h0, 0);
      chk("E valid", s_ov, 1); chk("E fault", s_of, 1);
      chk("E instr", s_oi, 32'h00000013); chk("E pc", s_opc, 32'h102); chk("E req", s_req, 0);
    end
    step(32'h102, 1, 0, 0, 32'h0, 0);
    step(32'h300, 0, 0, 0, 32'h0, 0);
    chk("E flushed valid", s_ov, 0); chk("E flushed fault", s_of, 0);

    // Reset while waiting; the late reply is ignored.
    step(32'h300, 0, 1, 0, 32'h0, 1);
    chk("F req", s_req, 1);
    do_reset();
    step(32'h300, 0, 0, 1, 32'hCAFEF00D, 0);
    chk("F valid", s_ov, 0); chk("F adv", s_adv, 0);
    chk("F instr", s_oi, 0); chk("F pc", s_opc, 0); chk("F fault", s_of, 0);
    step(32'h300, 0, 0, 0, 32'h0, 0);
    chk("F valid after", s_ov, 0); chk("F instr after", s_oi, 0);

    // Random traffic.
    pc = 32'h300;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        continue;
      end
      fl  = ($urandom_range(0, 15) == 0);
      g   = ($urandom_range(0, 2) != 0);
      rv  = mem_pend && (mem_cnt == 0);
      rd  = rv ? mem_data : $urandom;
      rdy = ($urandom_range(0, 3) != 0);
      step(pc, fl, g, rv, rd, rdy);
      if (rv) mem_pend = 0;
      else if (mem_pend) mem_cnt--;
      if (e_req && g) begin
        mem_pend = 1;
        mem_cnt  = int'($urandom_range(0, 2));
        mem_data = $urandom;
      end
      if (fl) pc = (32'($urandom_range(0, 1023)) << 2)
                   | (($urandom_range(0, 3) == 0) ? 32'd2 : 32'd0);
      else if (e_adv) pc = pc + 32'd4;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
